// File: rtl/id_ex_stage_pkg.sv
// id_defs: opcode/funct constants, aluOp codes, control and ID/EX bundles
// shared by the decode stage, its decoder and the ID/EX register.
package id_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_PASS = 4'd15;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       branch;
    logic       bne;
    logic       jump;
    logic [3:0] aluOp;
    logic       zeroExt;
    logic       rType;
    logic       usesRt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        aluSrc;
    logic        branch;
    logic        bne;
    logic        jump;
    logic [3:0]  aluOp;
    logic [31:0] pc4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID -> ID handshake: instruction bundle forward, stall back.
interface id_ex_stage_if;
  import id_defs::*;

  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        stall;

  modport master (
    output if_instr, if_pc4, if_valid,
    input  stall
  );

  modport slave (
    input  if_instr, if_pc4, if_valid,
    output stall
  );
endinterface

// File: rtl/id_ex_stage_decoder.sv
// id_decoder: combinational opcode/funct decode to the control bundle.
// Unknown encodings decode to the bubble vector and pulse illegal.
module id_decoder
  import id_defs::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       bad;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // decode table; the all-zero word is a nop with no register write
  always_comb begin
    ctrl = CTRL_BUBBLE;
    bad  = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.rType    = 1'b1;
        ctrl.usesRt   = 1'b1;
        ctrl.regWrite = 1'b1;
        unique case (1'b1)
          fn == FN_ADD: ctrl.aluOp = ALU_ADD;
          fn == FN_SUB: ctrl.aluOp = ALU_SUB;
          fn == FN_AND: ctrl.aluOp = ALU_AND;
          fn == FN_OR:  ctrl.aluOp = ALU_OR;
          fn == FN_SLT: ctrl.aluOp = ALU_SLT;
          fn == FN_SLL: ctrl.aluOp = ALU_SLL;
          default:      bad = 1'b1;
        endcase
      end
      op == OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      op == OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.usesRt   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      op == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.usesRt = 1'b1;
        ctrl.aluOp  = ALU_SUB;
      end
      op == OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
        ctrl.usesRt = 1'b1;
        ctrl.aluOp  = ALU_SUB;
      end
      op == OP_ADDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      op == OP_ANDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.zeroExt  = 1'b1;
        ctrl.aluOp    = ALU_AND;
      end
      op == OP_ORI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.zeroExt  = 1'b1;
        ctrl.aluOp    = ALU_OR;
      end
      op == OP_J: begin
        ctrl.jump  = 1'b1;
        ctrl.aluOp = ALU_PASS;
      end
      default: bad = 1'b1;
    endcase
    if (instr == 32'd0) ctrl.regWrite = 1'b0;
    if (bad) ctrl = CTRL_BUBBLE;
    illegal = valid & bad;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, load-use hazard, flush and the ID/EX register.
// Optional feature macro: ID_WB_BYPASS_EN (same-cycle writeback bypass).
module id_ex_stage
  import id_defs::*;
(
  input  logic         clock_in,
  input  logic         reset,
  id_ex_stage_if.slave ifId,
  output logic [4:0]   readReg1,
  output logic [4:0]   readReg2,
  input  logic [31:0]  readData1,
  input  logic [31:0]  readData2,
  input  logic         wb_regWrite,
  input  logic [4:0]   wb_writeReg,
  input  logic [31:0]  wb_writeData,
  input  logic         ex_flush,
  output logic         ex_valid,
  output logic         ex_regWrite,
  output logic         ex_memRead,
  output logic         ex_memWrite,
  output logic         ex_memToReg,
  output logic         ex_aluSrc,
  output logic         ex_branch,
  output logic         ex_bne,
  output logic         ex_jump,
  output logic [3:0]   ex_aluOp,
  output logic [31:0]  ex_pc4,
  output logic [31:0]  ex_rsData,
  output logic [31:0]  ex_rtData,
  output logic [31:0]  ex_imm,
  output logic [4:0]   ex_rs,
  output logic [4:0]   ex_rt,
  output logic [4:0]   ex_dest,
  output logic         illegal,
  output logic [15:0]  stall_count
);

  ctrl_t       dc;
  logic        decIll;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard;
  logic        load;
  logic [31:0] rsVal;
  logic [31:0] rtVal;
  id_ex_t      idEx;
  id_ex_t      nxt;

  assign rs       = ifId.if_instr[25:21];
  assign rt       = ifId.if_instr[20:16];
  assign readReg1 = rs;
  assign readReg2 = rt;

  id_decoder u_dec (
    .instr   (ifId.if_instr),
    .valid   (ifId.if_valid),
    .ctrl    (dc),
    .illegal (decIll)
  );

  assign hazard = ifId.if_valid & idEx.valid & idEx.memRead
                & (idEx.dest != 5'd0)
                & ((idEx.dest == rs) | (dc.usesRt & (idEx.dest == rt)));

  assign ifId.stall = hazard & ~ex_flush;
  assign load = ifId.if_valid & ~ex_flush & ~hazard & ~decIll;

`ifdef ID_WB_BYPASS_EN
  // take the writeback value when it targets a register being read now
  always_comb begin
    rsVal = readData1;
    rtVal = readData2;
    if (wb_regWrite && wb_writeReg != 5'd0) begin
      if (wb_writeReg == rs) rsVal = wb_writeData;
      if (wb_writeReg == rt) rtVal = wb_writeData;
    end
  end
`else
  logic unusedWb;
  assign unusedWb = ^{wb_regWrite, wb_writeReg, wb_writeData};
  assign rsVal = readData1;
  assign rtVal = readData2;
`endif

  // next ID/EX contents: decoded instruction or an all-zero bubble
  always_comb begin
    nxt = ID_EX_BUBBLE;
    if (load) begin
      nxt.valid    = 1'b1;
      nxt.regWrite = dc.regWrite;
      nxt.memRead  = dc.memRead;
      nxt.memWrite = dc.memWrite;
      nxt.memToReg = dc.memToReg;
      nxt.aluSrc   = dc.aluSrc;
      nxt.branch   = dc.branch;
      nxt.bne      = dc.bne;
      nxt.jump     = dc.jump;
      nxt.aluOp    = dc.aluOp;
      nxt.pc4      = ifId.if_pc4;
      nxt.rsData   = rsVal;
      nxt.rtData   = rtVal;
      nxt.imm      = dc.zeroExt
                   ? {16'd0, ifId.if_instr[15:0]}
                   : {{16{ifId.if_instr[15]}}, ifId.if_instr[15:0]};
      nxt.rs       = rs;
      nxt.rt       = rt;
      nxt.dest     = dc.rType ? ifId.if_instr[15:11] : rt;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) idEx <= ID_EX_BUBBLE;
    else        idEx <= nxt;
  end

  // sticky illegal flag and saturating stall counter
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      illegal     <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (decIll) illegal <= 1'b1;
      if (ifId.stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign ex_valid    = idEx.valid;
  assign ex_regWrite = idEx.regWrite;
  assign ex_memRead  = idEx.memRead;
  assign ex_memWrite = idEx.memWrite;
  assign ex_memToReg = idEx.memToReg;
  assign ex_aluSrc   = idEx.aluSrc;
  assign ex_branch   = idEx.branch;
  assign ex_bne      = idEx.bne;
  assign ex_jump     = idEx.jump;
  assign ex_aluOp    = idEx.aluOp;
  assign ex_pc4      = idEx.pc4;
  assign ex_rsData   = idEx.rsData;
  assign ex_rtData   = idEx.rtData;
  assign ex_imm      = idEx.imm;
  assign ex_rs       = idEx.rs;
  assign ex_rt       = idEx.rt;
  assign ex_dest     = idEx.dest;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Instruction-decode stage and ID/EX pipeline register of the five-stage pipeline. It drives the register file's two read addresses from the IF/ID instruction and decodes the opcode/funct into EX/MEM/WB control. It captures operands, immediate and control into the ID/EX register on each rising clock. It also detects load-use hazards (stall plus bubble), applies branch flushes, and optionally bypasses the same-cycle writeback value.

## Interface
- No parameters; widths fixed: data 32, register index 5, aluOp 4.
- clock_in  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- if_instr  in  32  instruction from IF/ID
- if_pc4  in  32  PC+4 from IF/ID
- if_valid  in  1  IF/ID holds a real instruction
- readReg1  out  5  = if_instr[25:21], combinational, to register file
- readReg2  out  5  = if_instr[20:16], combinational, to register file
- readData1, readData2  in  32 each  register file outputs
- wb_regWrite, wb_writeReg[4:0], wb_writeData[31:0]  in  writeback port, the same signals driving the register file
- ex_flush  in  1  branch/jump resolved taken in EX; kill the ID instruction
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch, ex_bne, ex_jump  out  1 each  registered control
- ex_aluOp  out  4  registered ALU operation
- ex_pc4, ex_rsData, ex_rtData, ex_imm  out  32 each  registered; ex_imm is sign-extended, except andi/ori, which are zero-extended
- ex_rs, ex_rt, ex_dest  out  5 each  registered; ex_dest = rd for R-type, rt for I-type
- illegal  out  1  sticky; set when a valid unknown opcode or funct is decoded
- stall_count  out  16  saturating count of stall cycles

## Operation
- Supported: R-type add/sub/and/or/slt/sll (opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A/0x00), lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, j 0x02.
- The all-zero instruction (sll $0) decodes as a nop: ex_valid=1 and all write/mem controls are 0.
- Unknown opcode/funct with if_valid=1: insert a bubble and set illegal, which stays set until reset.
- Load-use hazard, all of the following true:
  - ex_valid, ex_memRead, ex_dest≠0 and if_valid
  - ex_dest equals rs of any instruction, or rt of R-type/sw/beq/bne.
- On a hazard: stall=1, and the next ID/EX load is a bubble.
- Bubble:
  - ex_valid=0 and every control output 0
  - Data fields are don't-care but are loaded as 0.
- Priority per cycle: ex_flush > hazard > normal load.
  - With ex_flush=1, stall is forced to 0 and a bubble is loaded.
- if_valid=0: bubble, stall=0.
- Writes to $0 are never forwarded. ex_dest=0 still propagates with ex_regWrite as decoded; the register file ignores it.
- stall_count increments on each rising edge with stall=1 and saturates at 0xFFFF.

## Timing
- Reset (reset=0), asynchronous:
  - all ex_* outputs 0, illegal=0, stall_count=0
  - readReg1/2 and stall remain combinational functions of inputs.
- Latency: an instruction present at IF/ID when edge N rises appears on ex_* after edge N. Throughput is one instruction per cycle absent hazards.
- A load-use hazard costs exactly one stall cycle. On the next cycle the load has left EX, so the hazard condition clears.
- Reset asserted mid-stall: the state clears immediately. After release, the first edge loads normally.
- Back-to-back flushes: each cycle with ex_flush loads a bubble; there is no extra delay.

## Configuration
- ID_WB_BYPASS_EN defined:
  - if wb_regWrite=1, wb_writeReg≠0 and wb_writeReg equals readReg1 (or readReg2), ex_rsData (or ex_rtData) captures wb_writeData instead of readData.
  - This removes the dependence on the register file's write-before-read ordering.
- ID_WB_BYPASS_EN undefined: ex_rsData/ex_rtData always capture readData1/readData2.

## Structure
- Shared package id_defs holds:
  - opcode and funct constants
  - aluOp encodings: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, PASS=15
  - the bubble control vector
- One sub-module, id_decoder: purely combinational opcode/funct decode to the control bundle and the illegal pulse.
- Hazard logic, bypass muxes, the pipeline register and stall_count live in id_ex_stage.

## Test plan
- Reset: hold reset=0 while driving add $3,$1,$2 with if_valid=1 -> all ex_* outputs 0 and stall_count=0. Release reset -> after one edge, ex_dest=3, ex_aluOp=ADD, ex_regWrite=1.
- Load-use: lw $5,4($1) then add $6,$5,$2 -> stall=1 for exactly one cycle, a bubble with ex_valid=0 follows, then add is loaded with ex_rs=5 and stall_count=1.
- Flush with hazard: create the load-use condition and assert ex_flush in the same cycle -> stall=0, a bubble is loaded, stall_count is unchanged.
- Bypass (ID_WB_BYPASS_EN): wb writes 0xDEADBEEF to $7 while ID decodes or $8,$7,$0 and readData1=0 -> ex_rsData=0xDEADBEEF. Same stimulus without the macro -> ex_rsData=0.
- Immediate/illegal:
  - ori $4,$0,0x8000 -> ex_imm=0x00008000
  - addi $4,$0,-1 -> ex_imm=0xFFFFFFFF
  - opcode 0x3F -> bubble; illegal=1 and stays 1.
- Saturation: force 65540 consecutive hazard cycles -> stall_count=0xFFFF.
